// File: rtl/key_rst_gen.sv
// Reset generator: board reset plus debounced push-button produce a stretched active-low
// reset that asserts asynchronously and releases synchronously to sys_clk.
module key_rst_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1000000,
    parameter int HOLD_CYCLES = 16
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key1,
    output logic       rst_n_out,
    output logic       led_out,
    output logic [7:0] press_cnt
);

    // state    | meaning
    // HOLD     | rst_n_out low, counting out the minimum reset width
    // WAIT_REL | hold done but key still down; stay in reset until release
    // RUN      | rst_n_out high, key presses accepted
    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        WAIT_REL = 2'd1,
        RUN      = 2'd2
    } state_t;

    localparam int DW = $clog2(DEB_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   key_s;
    logic                   deb_key;
    logic                   deb_key_d;
    logic [DW-1:0]          deb_cnt;
    logic                   press;
    logic [HW-1:0]          hold_cnt;
    state_t                 state;
    state_t                 state_next;

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], key1};
        end
    end

    assign key_s = sync[SYNC_STAGES-1];

    // Any sample agreeing with the accepted level restarts the stability count.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            deb_key   <= 1'b1;
            deb_key_d <= 1'b1;
            deb_cnt   <= '0;
        end else begin
            deb_key_d <= deb_key;
            if (key_s == deb_key) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb_key <= key_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

    assign press = deb_key_d & ~deb_key;

    always_comb begin
        state_next = state;
        case (state)
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    state_next = deb_key ? RUN : WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (deb_key) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (press) begin
                    state_next = HOLD;
                end
            end
            default: state_next = HOLD;
        endcase
    end

    // rst_n_out is loaded from the next state so it is a clean flop output tracking RUN.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= HOLD;
            hold_cnt  <= '0;
            rst_n_out <= 1'b0;
            led_out   <= 1'b0;
            press_cnt <= 8'd0;
        end else begin
            state     <= state_next;
            rst_n_out <= (state_next == RUN);
            if (state == HOLD && hold_cnt != HOLD_LAST) begin
                hold_cnt <= hold_cnt + HW'(1);
            end else begin
                hold_cnt <= '0;
            end
            if (state == RUN && press) begin
                led_out <= ~led_out;
                if (press_cnt != 8'hFF) begin
                    press_cnt <= press_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_key_rst_gen.sv
// Directed bench for key_rst_gen with DEB_CYCLES=4, HOLD_CYCLES=8, SYNC_STAGES=2, 20 ns clock.
module tb_key_rst_gen;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key1    = 1'b1;
    logic       rst_n_out;
    logic       led_out;
    logic [7:0] press_cnt;

    int vectors     = 0;
    int miscompares = 0;

    key_rst_gen #(
        .SYNC_STAGES(2),
        .DEB_CYCLES (4),
        .HOLD_CYCLES(8)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key1     (key1),
        .rst_n_out(rst_n_out),
        .led_out  (led_out),
        .press_cnt(press_cnt)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    // Called just after a clock edge; asserts and releases sys_rst between edges.
    task automatic async_rst(input string tag);
        #6 sys_rst = 1'b0;
        #1;
        chk({tag, "_rst"}, 32'(rst_n_out), 0);
        chk({tag, "_led"}, 32'(led_out), 0);
        chk({tag, "_cnt"}, 32'(press_cnt), 0);
        #4 sys_rst = 1'b1;
    endtask

    task automatic hold_check(input string tag);
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk({tag, "_hold"}, 32'(rst_n_out), (e >= 8) ? 1 : 0);
        end
    endtask

    task automatic press_release();
        int waited;
        key1 = 1'b0;
        repeat (8) tick();
        key1 = 1'b1;
        waited = 0;
        while (rst_n_out !== 1'b1 && waited < 40) begin
            tick();
            waited++;
        end
        chk("sat_release", 32'(rst_n_out), 1);
        repeat (2) tick();
    endtask

    initial begin
        logic [11:0] pat;
        int          lows;
        int          falls;
        logic        prev;

        #2 sys_rst = 1'b0;
        #1 chk("por_rst", 32'(rst_n_out), 0);
        #2 sys_rst = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk("por_hold", 32'(rst_n_out), (e >= 8) ? 1 : 0);
        end
        chk("por_led", 32'(led_out), 0);
        chk("por_cnt", 32'(press_cnt), 0);

        // Clean press held 20 cycles: falls 6 edges after first sample, WAIT_REL until release.
        key1 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("press_rst", 32'(rst_n_out), (i < 7) ? 1 : 0);
            if (i == 7) begin
                chk("press_cnt", 32'(press_cnt), 1);
                chk("press_led", 32'(led_out), 1);
            end
        end
        key1 = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("release_rst", 32'(rst_n_out), (i == 7) ? 1 : 0);
        end

        async_rst("mid_run");
        hold_check("after_run");
        async_rst("pre_hold");
        repeat (3) tick();
        async_rst("mid_hold");
        hold_check("after_hold");

        for (int p = 0; p < 5; p++) begin
            key1 = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                chk("short_rst", 32'(rst_n_out), 1);
            end
            key1 = 1'b1;
            for (int i = 0; i < 6; i++) begin
                tick();
                chk("short_rst", 32'(rst_n_out), 1);
            end
        end
        chk("short_cnt", 32'(press_cnt), 0);
        chk("short_led", 32'(led_out), 0);

        pat   = 12'b0000_0000_1010;
        lows  = 0;
        falls = 0;
        prev  = rst_n_out;
        for (int i = 0; i < 12; i++) begin
            key1 = pat[i];
            tick();
            if (!rst_n_out) lows++;
            if (prev && !rst_n_out) falls++;
            prev = rst_n_out;
        end
        key1 = 1'b1;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (!rst_n_out) lows++;
            if (prev && !rst_n_out) falls++;
            prev = rst_n_out;
        end
        chk("bounce_falls", 32'(falls), 1);
        chk("bounce_lows", 32'(lows), 8);
        chk("bounce_cnt", 32'(press_cnt), 1);

        // Key held through reset release: press lands in HOLD, then WAIT_REL until release.
        key1    = 1'b0;
        sys_rst = 1'b0;
        #5 sys_rst = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk("held_rst", 32'(rst_n_out), 0);
        end
        key1 = 1'b1;
        for (int e = 13; e <= 19; e++) begin
            tick();
            chk("held_release", 32'(rst_n_out), (e == 19) ? 1 : 0);
        end
        chk("held_cnt", 32'(press_cnt), 0);
        chk("held_led", 32'(led_out), 0);

        for (int n = 1; n <= 260; n++) begin
            press_release();
            if (n == 255) begin
                chk("sat_cnt_255", 32'(press_cnt), 255);
                chk("sat_led_255", 32'(led_out), 1);
            end
        end
        chk("sat_cnt_end", 32'(press_cnt), 255);
        chk("sat_led_end", 32'(led_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
